inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous queue clear (branch mispredict / exception).
REQ-005 SHALL have port i_set1  input  PC_set  older decoded instruction from decoder.
REQ-006 SHALL have port i_set2  input  PC_set  younger decoded instruction from decoder.
REQ-007 SHALL have port i_valid  input  2  enqueue request; bit1 = i_set1, bit0 = i_set2.
REQ-008 SHALL have port o_ready  output  1  queue can accept two entries this cycle.
REQ-009 SHALL have port i_usingNUM  input  2  entries consumed by dispatch this cycle (0, 1 or 2).
REQ-010 SHALL have port o_set1  output  PC_set  head entry.
REQ-011 SHALL have port o_set2  output  PC_set  entry at head+1.
REQ-012 SHALL have port o_is_valid  output  2  bit1 = o_set1 valid, bit0 = o_set2 valid.

Function
REQ-013 SHALL store entries in a circular array with head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-014 SHALL drive o_ready = 1 when (DEPTH - count) >= 2, from registered count only; same-cycle dequeue does not free space.
REQ-015 SHALL ignore i_valid while o_ready = 0; the decoder holds its outputs.
REQ-016 SHALL enqueue when o_ready = 1: i_valid 2'b11 writes i_set1 at tail and i_set2 at tail+1 (enq = 2); 2'b10 writes i_set1 only; 2'b01 writes i_set2 only; 2'b00 writes nothing.
REQ-017 SHALL dequeue deq = i_usingNUM, clamped to count; i_usingNUM = 2'b11 is treated as 0.
REQ-018 SHALL update count_next = count + enq - deq, tail += enq, head += deq, all on the same edge; simultaneous enqueue and dequeue is legal.
REQ-019 SHALL drive o_is_valid = {count >= 1, count >= 2} combinationally from registered count.
REQ-020 SHALL drive o_set1/o_set2 combinationally from array[head] and array[head+1] (wrapping), with their o_valid fields equal to o_is_valid[1] and o_is_valid[0] respectively.
REQ-021 SHALL impose one-cycle latency: an entry written at edge N is visible on o_set* after edge N; no enqueue-to-output bypass.
REQ-022 SHALL preserve program order: i_set1 precedes i_set2; entries leave in insertion order.
REQ-023 SHALL, on flush = 1, set head, tail and count to 0 at the next edge, overriding that cycle's enqueue and dequeue.
REQ-024 SHALL never overflow: count <= DEPTH holds at all times given REQ-014/015.

Reset
REQ-025 SHALL on rstn = 0 asynchronously clear head, tail and count to 0, giving o_is_valid = 2'b00 and o_ready = 1.
REQ-026 SHALL leave array contents unreset; they are unobservable while invalid.
REQ-027 SHALL resume normal operation on the first rising edge after rstn deasserts, including when reset was asserted mid-transfer.

Structure
REQ-028 SHALL take PC_set from package Public_Info; constant IQ_DEPTH (= 8) SHALL be added there and bound to DEPTH at instantiation.
REQ-029 SHALL be a single module with no sub-module; storage is a flat register array of PC_set.
REQ-030 SHALL connect o_set1/o_set2/o_is_valid directly to the issue-dispatch stage and take i_usingNUM from its o_usingNUM.

Verification
REQ-031 SHALL cover: reset, then i_valid = 2'b11 for one cycle with i_usingNUM = 0 -> next cycle o_is_valid = 2'b11, count = 2, o_set1.PC = i_set1.PC.
REQ-032 SHALL cover: i_valid = 2'b11 each cycle with i_usingNUM = 0 -> o_ready drops to 0 when count = 7 (DEPTH 8), no further writes, count stays 7.
REQ-033 SHALL cover: count = 3, i_valid = 2'b11 and i_usingNUM = 1 on the same edge -> count = 4, head advances by 1, order preserved.
REQ-034 SHALL cover: wrap-around, 20 entries pushed and popped with head starting at 6 -> PCs emerge in exact insertion order across the index 7 -> 0 boundary.
REQ-035 SHALL cover: count = 5, flush = 1 with i_valid = 2'b11 and i_usingNUM = 2 -> next cycle count = 0, o_is_valid = 2'b00, o_ready = 1.
REQ-036 SHALL cover: count = 1, i_usingNUM = 2 -> deq clamped to 1, count = 0; and rstn pulsed low mid-stream -> outputs clear immediately without waiting for clk.

Source files
------------

// File: rtl/Public_Info.sv
// Shared front-end types: the decoded-instruction record passed between
// decoder, instruction queue and issue-dispatch, plus the queue depth.
// Pure type/constant package; no logic, no latency, no flow control.
package Public_Info;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] PC;       // instruction address
        logic [31:0] inst;     // raw/decoded instruction word
        logic        o_valid;  // entry valid as seen by the consumer
    } PC_set;

endpackage

// File: rtl/inst_queue.sv
// Purpose : circular instruction queue between decode (2-wide enqueue) and
//           issue-dispatch (0..2 entries consumed per cycle).
// Latency : one cycle enqueue-to-output, no bypass; head outputs are
//           combinational from registered state.
// Backpressure: o_ready = space for two entries, from registered count only;
//           i_valid is ignored while o_ready is low (decoder holds).
// Ports   : clk/rstn (async active-low), flush (sync clear), i_set1/i_set2 +
//           i_valid enqueue side, i_usingNUM dequeue count, o_set1/o_set2 +
//           o_is_valid head window, o_ready.
module inst_queue
    import Public_Info::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  PC_set       i_set1,
    input  PC_set       i_set2,
    input  logic [1:0]  i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_usingNUM,
    output PC_set       o_set1,
    output PC_set       o_set2,
    output logic [1:0]  o_is_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    PC_set         mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_p1, tail_p1;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    enq, deq;

    // Pointer arithmetic relies on AW-bit wrap for modulo DEPTH.
    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    always_comb begin
        o_ready    = (count_q <= READY_MAX);
        o_is_valid = {count_q >= (AW+1)'(1), count_q >= (AW+1)'(2)};

        enq = 2'd0;
        if (o_ready) begin
            case (i_valid)
                2'b11:        enq = 2'd2;
                2'b10, 2'b01: enq = 2'd1;
                default:      enq = 2'd0;
            endcase
        end

        // Clamp consumption to what is actually held; 2'b11 is not a legal
        // request and is treated as no consumption.
        deq = 2'd0;
        case (i_usingNUM)
            2'd1:    deq = (count_q >= (AW+1)'(1)) ? 2'd1 : 2'd0;
            2'd2:    deq = (count_q >= (AW+1)'(2)) ? 2'd2 : count_q[1:0];
            default: deq = 2'd0;
        endcase

        head_d  = head_q + AW'(deq);
        tail_d  = tail_q + AW'(enq);
        count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset: contents are masked by o_is_valid.
    // A lone i_set2 still lands at tail so program order is kept.
    always_ff @(posedge clk) begin
        if (o_ready && !flush) begin
            case (i_valid)
                2'b11: begin
                    mem_q[tail_q]  <= i_set1;
                    mem_q[tail_p1] <= i_set2;
                end
                2'b10:   mem_q[tail_q] <= i_set1;
                2'b01:   mem_q[tail_q] <= i_set2;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_set1         = mem_q[head_q];
        o_set2         = mem_q[head_p1];
        o_set1.o_valid = o_is_valid[1];
        o_set2.o_valid = o_is_valid[0];
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    import Public_Info::*;

    logic        clk;
    logic        rstn;
    logic        flush;
    PC_set       i_set1, i_set2;
    logic [1:0]  i_valid;
    logic        o_ready;
    logic [1:0]  i_usingNUM;
    PC_set       o_set1, o_set2;
    logic [1:0]  o_is_valid;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] pc = 32'h1000;
    logic [31:0] mq [$];
    logic [2:0]  head_snap;

    inst_queue #(.DEPTH(IQ_DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .i_set1     (i_set1),
        .i_set2     (i_set2),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_usingNUM (i_usingNUM),
        .o_set1     (o_set1),
        .o_set2     (o_set2),
        .o_is_valid (o_is_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the reference queue contents.
    task automatic chk_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".ready"}, {31'd0, o_ready}, ((8 - n) >= 2) ? 32'd1 : 32'd0);
        chk({tag, ".isval"}, {30'd0, o_is_valid}, {30'd0, n >= 1, n >= 2});
        chk({tag, ".count"}, 32'(dut.count_q), 32'(n));
        if (n >= 1) begin
            chk({tag, ".pc1"}, o_set1.PC, mq[0]);
            chk({tag, ".v1"},  {31'd0, o_set1.o_valid}, 32'd1);
        end
        if (n >= 2) begin
            chk({tag, ".pc2"}, o_set2.PC, mq[1]);
            chk({tag, ".v2"},  {31'd0, o_set2.o_valid}, 32'd1);
        end
    endtask

    // Apply one cycle of stimulus, update the reference queue, then check.
    task automatic cyc(input string tag, input logic [1:0] v, input logic [1:0] u, input logic f);
        int  n;
        int  d;
        bit  rdy;
        n   = mq.size();
        rdy = ((8 - n) >= 2);
        flush        = f;
        i_valid      = v;
        i_usingNUM   = u;
        i_set1.PC    = pc;
        i_set1.inst  = ~pc;
        i_set2.PC    = pc + 32'd4;
        i_set2.inst  = ~(pc + 32'd4);
        if (f) begin
            mq.delete();
        end else begin
            d = (u == 2'd3) ? 0 : ((int'(u) > n) ? n : int'(u));
            repeat (d) void'(mq.pop_front());
            if (rdy) begin
                if (v[1]) mq.push_back(pc);
                if (v[0]) mq.push_back(pc + 32'd4);
            end
        end
        pc = pc + 32'd8;
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rstn         = 1'b0;
        flush        = 1'b0;
        i_valid      = 2'b00;
        i_usingNUM   = 2'd0;
        i_set1       = '0;
        i_set2       = '0;
        i_set1.o_valid = 1'b1;
        i_set2.o_valid = 1'b1;

        // Reset state
        #12;
        chk("rst.isval", {30'd0, o_is_valid}, 32'd0);
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        chk("rst.count", 32'(dut.count_q), 32'd0);
        rstn = 1'b1;

        // First pair visible one cycle later
        cyc("pair", 2'b11, 2'd0, 1'b0);
        chk("pair.count", 32'(dut.count_q), 32'd2);
        chk("pair.pc1", o_set1.PC, 32'h1000);
        chk("pair.pc2", o_set2.PC, 32'h1004);

        // Single older, then single younger entry
        cyc("one1", 2'b10, 2'd0, 1'b0);           // count 3
        cyc("one0", 2'b01, 2'd0, 1'b0);           // count 4
        chk("one0.count", 32'(dut.count_q), 32'd4);
        cyc("deq1", 2'b00, 2'd1, 1'b0);           // count 3
        // Fill: 3 -> 5 -> 7, then o_ready low and count holds at 7
        cyc("fill5", 2'b11, 2'd0, 1'b0);
        cyc("fill7", 2'b11, 2'd0, 1'b0);
        chk("full.ready", {31'd0, o_ready}, 32'd0);
        chk("full.count", 32'(dut.count_q), 32'd7);
        cyc("hold1", 2'b11, 2'd0, 1'b0);
        cyc("hold2", 2'b11, 2'd0, 1'b0);
        chk("hold.count", 32'(dut.count_q), 32'd7);
        // usingNUM = 3 consumes nothing
        cyc("u3", 2'b00, 2'd3, 1'b0);
        chk("u3.count", 32'(dut.count_q), 32'd7);

        // Drain to 3, then simultaneous enqueue 2 / dequeue 1
        cyc("dr5", 2'b00, 2'd2, 1'b0);
        cyc("dr3", 2'b00, 2'd2, 1'b0);
        head_snap = dut.head_q;
        cyc("mix", 2'b11, 2'd1, 1'b0);
        chk("mix.count", 32'(dut.count_q), 32'd4);
        chk("mix.head", 32'(dut.head_q), 32'(head_snap + 3'd1));

        // Wrap-around: flush, advance head to 6, then stream 20 entries
        cyc("wfl", 2'b00, 2'd0, 1'b1);
        chk("wfl.head", 32'(dut.head_q), 32'd0);
        cyc("w2", 2'b11, 2'd0, 1'b0);
        cyc("w4", 2'b11, 2'd0, 1'b0);
        cyc("w6", 2'b11, 2'd0, 1'b0);
        cyc("p4", 2'b00, 2'd2, 1'b0);
        cyc("p2", 2'b00, 2'd2, 1'b0);
        cyc("p0", 2'b00, 2'd2, 1'b0);
        chk("wrap.head", 32'(dut.head_q), 32'd6);
        for (int k = 0; k < 10; k++) cyc("wstream", 2'b11, (k == 0) ? 2'd0 : 2'd2, 1'b0);
        for (int k = 0; k < 2; k++)  cyc("wdrain", 2'b00, 2'd2, 1'b0);
        chk("wrap.count", 32'(dut.count_q), 32'd0);

        // Flush at count 5 overrides same-cycle enqueue and dequeue
        cyc("f2", 2'b11, 2'd0, 1'b0);
        cyc("f4", 2'b11, 2'd0, 1'b0);
        cyc("f5", 2'b10, 2'd0, 1'b0);
        chk("f5.count", 32'(dut.count_q), 32'd5);
        cyc("flush", 2'b11, 2'd2, 1'b1);
        chk("flush.count", 32'(dut.count_q), 32'd0);
        chk("flush.isval", {30'd0, o_is_valid}, 32'd0);
        chk("flush.ready", {31'd0, o_ready}, 32'd1);

        // Dequeue of 2 with one entry is clamped to 1
        cyc("c1", 2'b10, 2'd0, 1'b0);
        cyc("clamp", 2'b00, 2'd2, 1'b0);
        chk("clamp.count", 32'(dut.count_q), 32'd0);

        // Asynchronous reset mid-stream, away from the clock edge
        cyc("r2", 2'b11, 2'd0, 1'b0);
        cyc("r4", 2'b11, 2'd1, 1'b0);
        i_valid = 2'b00;
        #2;
        rstn = 1'b0;
        mq.delete();
        #1;
        chk("arst.isval", {30'd0, o_is_valid}, 32'd0);
        chk("arst.ready", {31'd0, o_ready}, 32'd1);
        chk("arst.count", 32'(dut.count_q), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc("resume", 2'b11, 2'd0, 1'b0);
        cyc("resume2", 2'b01, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
